// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
//
// Purpose:
//   Request/response bus between the instruction fetch unit and the
//   instruction memory port. It carries a read command channel and a
//   read-data return channel.
//
// Signals:
//   imem_addr    request address (word aligned)
//   imem_cmd     command, 0 = read
//   imem_size    access size, 2'b10 = word
//   imem_valid   request valid
//   imem_ready   request accepted when valid && ready
//   imem_r_valid read data valid
//   imem_r_ready read data can be accepted
//   imem_r_data  read data
//   imem_r_resp  error response for this read
//
// Modports:
//   master  fetch side (drives requests, consumes read data)
//   slave   memory side
// ---------------------------------------------------------------------------
interface ifetch_unit_if #(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32
);

  logic [p_ADDR_BITS-1:0] imem_addr;
  logic                   imem_cmd;
  logic [1:0]             imem_size;
  logic                   imem_valid;
  logic                   imem_ready;
  logic                   imem_r_valid;
  logic                   imem_r_ready;
  logic [p_DATA_BITS-1:0] imem_r_data;
  logic                   imem_r_resp;

  modport master (
    output imem_addr,
    output imem_cmd,
    output imem_size,
    output imem_valid,
    output imem_r_ready,
    input  imem_ready,
    input  imem_r_valid,
    input  imem_r_data,
    input  imem_r_resp
  );

  modport slave (
    input  imem_addr,
    input  imem_cmd,
    input  imem_size,
    input  imem_valid,
    input  imem_r_ready,
    output imem_ready,
    output imem_r_valid,
    output imem_r_data,
    output imem_r_resp
  );

endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Purpose:
//   Instruction fetch front-end. It generates sequential word-aligned PCs,
//   issues read requests on the imem port under a credit limit, and buffers
//   returned words together with their PCs in a small FIFO for decode.
//   A redirect flushes the FIFO, restarts fetch at the new PC and discards
//   all responses still in flight for the old stream.
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-low reset
//   redirect_valid  one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc     new fetch address (low two bits ignored)
//   imem            ifetch_unit_if.master, request/response memory bus
//   inst_valid      instruction available to decode
//   inst_ready      decode accepts the current instruction
//   inst_data       instruction word
//   inst_pc         PC of inst_data
//   inst_err        memory reported an error for this word
//
// Configuration:
//   IFETCH_BYPASS_EN  when defined, a response arriving while the FIFO is
//                     empty (and nothing is being dropped or redirected) is
//                     presented on inst_* in the same cycle and, if decode
//                     accepts it, never written into the FIFO.
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter int                     p_ADDR_BITS = 32,
  parameter int                     p_DATA_BITS = 32,
  parameter logic [p_ADDR_BITS-1:0] p_RESET_PC  = '0,
  parameter int                     p_DEPTH     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [p_ADDR_BITS-1:0] redirect_pc,
  ifetch_unit_if.master          imem,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [p_DATA_BITS-1:0] inst_data,
  output logic [p_ADDR_BITS-1:0] inst_pc,
  output logic                   inst_err
);

  // Counters must hold 0..p_DEPTH inclusive; pointers index p_DEPTH slots.
  localparam int CW = $clog2(p_DEPTH + 1);
  localparam int PW = $clog2(p_DEPTH);
  localparam int WA = p_ADDR_BITS - 2;

  // The request PC is kept as a word index so it is aligned by construction.
  logic [WA-1:0]          pc_req_q, pc_req_d;
  logic [CW-1:0]          outstanding_q, outstanding_d;
  logic [CW-1:0]          drop_q, drop_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          pcq_rd_q, pcq_rd_d;
  logic [PW-1:0]          pcq_wr_q, pcq_wr_d;
  logic [p_DATA_BITS-1:0] fifo_data_q [0:p_DEPTH-1];
  logic [p_DATA_BITS-1:0] fifo_data_d [0:p_DEPTH-1];
  logic [p_ADDR_BITS-1:0] fifo_pc_q   [0:p_DEPTH-1];
  logic [p_ADDR_BITS-1:0] fifo_pc_d   [0:p_DEPTH-1];
  logic                   fifo_err_q  [0:p_DEPTH-1];
  logic                   fifo_err_d  [0:p_DEPTH-1];
  logic [WA-1:0]          pcq_q       [0:p_DEPTH-1];
  logic [WA-1:0]          pcq_d       [0:p_DEPTH-1];

  logic                   credit_ok;
  logic                   issue_valid;
  logic                   issue;
  logic                   resp;
  logic [p_ADDR_BITS-1:0] resp_pc;
  logic                   dropping;
  logic                   fifo_empty;
  logic                   bypass;
  logic                   push;
  logic                   pop;

  // Only the word-index part of the redirect target matters.
  logic                   unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Fixed request attributes: word reads only, read data always accepted
  // because credits reserve a FIFO slot for every outstanding request.
  assign imem.imem_cmd     = 1'b0;
  assign imem.imem_size    = 2'b10;
  assign imem.imem_r_ready = 1'b1;
  assign imem.imem_addr    = {pc_req_q, 2'b00};

  // Request and response qualification, plus the decode-side view.
  // imem_valid is gated by rst so it reads 0 while reset is held.
  always_comb begin
    credit_ok   = ((CW+1)'(count_q) + (CW+1)'(outstanding_q)) < (CW+1)'(p_DEPTH);
    issue_valid = rst && !redirect_valid && credit_ok;
    issue       = issue_valid && imem.imem_ready;
    resp        = imem.imem_r_valid;
    resp_pc     = {pcq_q[pcq_rd_q], 2'b00};
    dropping    = (drop_q != '0);
    fifo_empty  = (count_q == '0);
`ifdef IFETCH_BYPASS_EN
    bypass      = resp && !dropping && fifo_empty && !redirect_valid;
`else
    bypass      = 1'b0;
`endif
    imem.imem_valid = issue_valid;
    inst_valid      = !fifo_empty || bypass;
    if (bypass) begin
      inst_data = imem.imem_r_data;
      inst_pc   = resp_pc;
      inst_err  = imem.imem_r_resp;
    end else begin
      inst_data = fifo_data_q[rd_ptr_q];
      inst_pc   = fifo_pc_q[rd_ptr_q];
      inst_err  = fifo_err_q[rd_ptr_q];
    end
    // A live response is buffered unless decode takes it straight off the
    // bypass path. Pops only come from the FIFO (bypass implies empty).
    push = resp && !redirect_valid && !dropping && !(bypass && inst_ready);
    pop  = !fifo_empty && inst_ready;
  end

  // Next-state for request PC, credit/drop counters, PC queue and FIFO.
  always_comb begin
    pc_req_d      = pc_req_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pcq_rd_d      = pcq_rd_q;
    pcq_wr_d      = pcq_wr_q;
    fifo_data_d   = fifo_data_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_err_d    = fifo_err_q;
    pcq_d         = pcq_q;

    // Every accepted request remembers its PC; every response retires the
    // oldest one, whether it is delivered or dropped.
    if (issue) begin
      pcq_d[pcq_wr_q] = pc_req_q;
      pcq_wr_d        = pcq_wr_q + PW'(1);
      pc_req_d        = pc_req_q + WA'(1);
    end
    if (resp) begin
      pcq_rd_d = pcq_rd_q + PW'(1);
    end
    outstanding_d = outstanding_q + CW'(issue) - CW'(resp);

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old
      // stream, so it all becomes drop credit; a response arriving now is
      // already being discarded.
      pc_req_d = redirect_pc[p_ADDR_BITS-1:2];
      drop_d   = outstanding_q - CW'(resp);
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (resp && dropping) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        fifo_data_d[wr_ptr_q] = imem.imem_r_data;
        fifo_pc_d[wr_ptr_q]   = resp_pc;
        fifo_err_d[wr_ptr_q]  = imem.imem_r_resp;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_req_q      <= p_RESET_PC[p_ADDR_BITS-1:2];
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pcq_rd_q      <= '0;
      pcq_wr_q      <= '0;
      fifo_data_q   <= '{default: '0};
      fifo_pc_q     <= '{default: '0};
      fifo_err_q    <= '{default: 1'b0};
      pcq_q         <= '{default: '0};
    end else begin
      pc_req_q      <= pc_req_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pcq_rd_q      <= pcq_rd_d;
      pcq_wr_q      <= pcq_wr_d;
      fifo_data_q   <= fifo_data_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_err_q    <= fifo_err_d;
      pcq_q         <= pcq_d;
    end
  end

  // A live response can never meet a full FIFO if the memory only answers
  // requests it accepted; catching it here points at the environment.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(imem.imem_r_valid && !redirect_valid && (drop_q == '0) &&
      (count_q == CW'(p_DEPTH))));

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Purpose:
//   Self-checking bench for ifetch_unit. A memory model answers accepted
//   requests in order after a random latency; a queue-based model of the
//   fetch stream predicts imem and inst outputs every cycle. Directed
//   phases pin the model with literal expectations; a random phase mixes
//   back-pressure, latency, errors, redirects and a mid-run reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifetch_unit;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_BYPASS_EN
  localparam bit          BYPASS   = 1'b1;
`else
  localparam bit          BYPASS   = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } infl_t;

  typedef struct {
    logic [31:0] addr;
    logic        err;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_err;

  ifetch_unit_if #(.p_ADDR_BITS(AW), .p_DATA_BITS(DW)) imem_bus ();

  ifetch_unit #(
    .p_ADDR_BITS(AW),
    .p_DATA_BITS(DW),
    .p_RESET_PC (RESET_PC),
    .p_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem          (imem_bus),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_err      (inst_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          first_iv = -1;

  int          ready_pct;
  int          inst_pct;
  int          lat_min;
  int          lat_max;
  int          err_mode;
  int          redir_pct;
  bit          redir_req;
  logic [31:0] redir_target;

  mreq_t       memq   [$];
  infl_t       inflq  [$];
  ent_t        fifoq  [$];
  ent_t        got    [$];
  logic [31:0] issued [$];
  logic [31:0] m_pc;

  function automatic logic [31:0] data_of(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]};
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic need(input string name, input bit cond);
    n_checks++;
    if (!cond) begin
      n_fail++;
      $display("[TB] FAIL %s: condition false (cycle %0d)", name, cyc);
    end
  endtask

  // Drive this cycle's inputs: decode/memory readiness, redirect and the
  // in-order memory response when its latency has elapsed.
  task automatic applyStimulus();
    inst_ready            = ($urandom_range(99) < inst_pct);
    imem_bus.imem_ready   = ($urandom_range(99) < ready_pct);
    redirect_valid        = redir_req || ($urandom_range(99) < redir_pct);
    redirect_pc           = redir_req ? redir_target : $urandom;
    redir_req             = 1'b0;
    imem_bus.imem_r_valid = 1'b0;
    imem_bus.imem_r_data  = $urandom;
    imem_bus.imem_r_resp  = 1'($urandom_range(1));
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_bus.imem_r_valid = 1'b1;
      imem_bus.imem_r_data  = data_of(memq[0].addr);
      imem_bus.imem_r_resp  = memq[0].err;
    end
  endtask

  function automatic bit exp_issue_valid();
    return rst && !redirect_valid && ((fifoq.size() + inflq.size()) < DEPTH);
  endfunction

  // Compare all DUT outputs against what the stream model says they must be.
  task automatic checkOutput();
    bit   exp_iv;
    bit   stale;
    bit   byp;
    bit   exp_inst_v;
    ent_t e;
    exp_iv = exp_issue_valid();
    compare("imem_valid", 32'(imem_bus.imem_valid), 32'(exp_iv));
    compare("imem_addr", imem_bus.imem_addr, m_pc);
    compare("imem_const", 32'({imem_bus.imem_cmd, imem_bus.imem_size, imem_bus.imem_r_ready}),
            32'h5);
    stale      = (inflq.size() > 0) && inflq[0].stale;
    byp        = BYPASS && imem_bus.imem_r_valid && !redirect_valid &&
                 (fifoq.size() == 0) && !stale && (inflq.size() > 0);
    exp_inst_v = (fifoq.size() > 0) || byp;
    compare("inst_valid", 32'(inst_valid), 32'(exp_inst_v));
    if (exp_inst_v) begin
      if (byp) begin
        e.data = imem_bus.imem_r_data;
        e.pc   = inflq[0].addr;
        e.err  = imem_bus.imem_r_resp;
      end else begin
        e = fifoq[0];
      end
      compare("inst_data", inst_data, e.data);
      compare("inst_pc", inst_pc, e.pc);
      compare("inst_err", 32'(inst_err), 32'(e.err));
    end
  endtask

  // Advance the stream model and memory model by one clock edge.
  task automatic advanceModel();
    infl_t       h;
    bit          have_h;
    bit          issue;
    bit          popf;
    bit          byp;
    logic [31:0] issue_addr;
    ent_t        e;
    mreq_t       m;
    issue      = exp_issue_valid() && imem_bus.imem_ready;
    issue_addr = m_pc;
    popf       = (fifoq.size() > 0) && inst_ready;
    if (inst_valid && first_iv < 0) first_iv = cyc;
    if (inst_valid && inst_ready) begin
      e.data = inst_data;
      e.pc   = inst_pc;
      e.err  = inst_err;
      got.push_back(e);
    end
    if (imem_bus.imem_valid && imem_bus.imem_ready) issued.push_back(imem_bus.imem_addr);
    have_h = 1'b0;
    if (imem_bus.imem_r_valid) begin
      if (inflq.size() > 0) begin
        h      = inflq.pop_front();
        have_h = 1'b1;
      end
      if (memq.size() > 0) void'(memq.pop_front());
    end
    if (redirect_valid) begin
      foreach (inflq[i]) inflq[i].stale = 1'b1;
      fifoq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      byp = BYPASS && have_h && !h.stale && (fifoq.size() == 0);
      if (popf) void'(fifoq.pop_front());
      if (have_h && !h.stale && !(byp && inst_ready)) begin
        e.data = imem_bus.imem_r_data;
        e.pc   = h.addr;
        e.err  = imem_bus.imem_r_resp;
        fifoq.push_back(e);
      end
      if (issue) begin
        h.addr  = issue_addr;
        h.stale = 1'b0;
        inflq.push_back(h);
        m_pc = m_pc + 32'd4;
      end
    end
    if (issue) begin
      m.addr = issue_addr;
      case (err_mode)
        1:       m.err = (issue_addr == 32'h8);
        2:       m.err = ($urandom_range(9) == 0);
        default: m.err = 1'b0;
      endcase
      m.due = cyc + int'($urandom_range(lat_max, lat_min));
      memq.push_back(m);
    end
    cyc++;
  endtask

  task automatic stepCycle();
    applyStimulus();
    #1;
    checkOutput();
    advanceModel();
    @(negedge clk);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst                   = 1'b0;
    redirect_valid        = 1'b0;
    redirect_pc           = '0;
    inst_ready            = 1'b0;
    imem_bus.imem_ready   = 1'b0;
    imem_bus.imem_r_valid = 1'b0;
    imem_bus.imem_r_data  = '0;
    imem_bus.imem_r_resp  = 1'b0;
    memq.delete();
    inflq.delete();
    fifoq.delete();
    got.delete();
    issued.delete();
    m_pc      = RESET_PC;
    redir_req = 1'b0;
    first_iv  = -1;
    #1;
    compare("rst_imem_valid", 32'(imem_bus.imem_valid), 32'h0);
    compare("rst_imem_addr", imem_bus.imem_addr, RESET_PC);
    compare("rst_inst_valid", 32'(inst_valid), 32'h0);
    compare("rst_inst_data", inst_data, 32'h0);
    compare("rst_inst_pc", inst_pc, 32'h0);
    compare("rst_inst_err", 32'(inst_err), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int n_before;
    rst = 1'b1;

    // Phase 1: streaming, 1-cycle memory, error on the word at 0x8.
    ready_pct = 100; inst_pct = 100; lat_min = 1; lat_max = 1;
    err_mode  = 1;   redir_pct = 0;
    resetDut();
    repeat (24) stepCycle();
    need("p1_issued_count", issued.size() >= 3);
    if (issued.size() >= 3) begin
      compare("p1_issue0", issued[0], 32'h0);
      compare("p1_issue1", issued[1], 32'h4);
      compare("p1_issue2", issued[2], 32'h8);
    end
    need("p1_got_count", got.size() >= 4);
    if (got.size() >= 4) begin
      compare("p1_pc0", got[0].pc, 32'h0);
      compare("p1_data1", got[1].data, 32'h0004_FFFB);
      compare("p1_pc2", got[2].pc, 32'h8);
      compare("p1_err2", 32'(got[2].err), 32'h1);
      compare("p1_pc3", got[3].pc, 32'hC);
      compare("p1_err3", 32'(got[3].err), 32'h0);
    end
    compare("p1_first_inst_cycle", 32'(first_iv), BYPASS ? 32'd1 : 32'd2);

    // Phase 2: decode stalled, only DEPTH requests may go out.
    err_mode = 0; inst_pct = 0;
    resetDut();
    repeat (10) stepCycle();
    compare("p2_issued_count", 32'(issued.size()), 32'd2);
    if (issued.size() >= 2) begin
      compare("p2_issue0", issued[0], 32'h0);
      compare("p2_issue1", issued[1], 32'h4);
    end
    compare("p2_stalled_valid", 32'(imem_bus.imem_valid), 32'h0);
    inst_pct = 100;
    repeat (10) stepCycle();
    need("p2_resume_count", issued.size() >= 3);
    if (issued.size() >= 3) compare("p2_resume_addr", issued[2], 32'h8);

    // Phase 3: redirect to an unaligned target with two reads in flight.
    lat_min = 3; lat_max = 3;
    resetDut();
    repeat (3) stepCycle();
    redir_req    = 1'b1;
    redir_target = 32'h0000_0102;
    n_before     = issued.size();
    got.delete();
    repeat (20) stepCycle();
    need("p3_issue_after", issued.size() > n_before);
    if (issued.size() > n_before) compare("p3_first_new_addr", issued[n_before], 32'h100);
    need("p3_got_count", got.size() >= 2);
    if (got.size() >= 2) begin
      compare("p3_pc0", got[0].pc, 32'h100);
      compare("p3_data0", got[0].data, 32'h0100_FEFF);
      compare("p3_pc1", got[1].pc, 32'h104);
    end

    // Phase 4: randomized traffic with a reset in the middle.
    err_mode  = 2;
    redir_pct = 4;
    resetDut();
    for (int blk = 0; blk < 16; blk++) begin
      ready_pct = int'($urandom_range(100, 30));
      inst_pct  = int'($urandom_range(100, 20));
      lat_min   = 1;
      lat_max   = int'($urandom_range(4, 1));
      if (blk == 8) resetDut();
      repeat (200) stepCycle();
    end
    need("p4_progress", got.size() > 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
